// File: rtl/reaction_timer_multi_if.sv
// Player-facing bundle of the reaction timer: control inputs and display/LED outputs.
interface reaction_timer_multi_if #(
    parameter int DIGITS  = 6,
    parameter int PLAYERS = 2,
    parameter int LEDS    = 10
);
    localparam int SEL_W = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;

    logic                  start;
    logic [PLAYERS-1:0]    react;
    logic                  show_best;
    logic [SEL_W-1:0]      best_sel;
    logic                  clear_best;
    logic [4*DIGITS-1:0]   bcd_disp;
    logic [LEDS-1:0]       led;
    logic [SEL_W-1:0]      winner;
    logic [2:0]            state_o;
    logic                  new_best;
    logic                  timeout;

    modport master (
        output start, react, show_best, best_sel, clear_best,
        input  bcd_disp, led, winner, state_o, new_best, timeout
    );

    modport slave (
        input  start, react, show_best, best_sel, clear_best,
        output bcd_disp, led, winner, state_o, new_best, timeout
    );
endinterface

// File: rtl/reaction_timer_multi.sv
// Multi-player reaction timer: random fore-period, BCD millisecond count,
// first-press arbitration, false-start detection and per-player best times.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset, waiting for a start edge
// WAIT  | random fore-period running; any press is a false start
// RUN   | stimulus on (all LEDs lit), BCD count advancing per tick
// DONE  | press captured (or count saturated -> timeout)
// FOUL  | false start captured during WAIT
module reaction_timer_multi #(
    parameter int DIGITS     = 6,
    parameter int PLAYERS    = 2,
    parameter int TICK_DIV   = 50000,
    parameter int MIN_DELAY  = 500,
    parameter int DELAY_MASK = 2047,
    parameter int LEDS       = 10
) (
    input  logic                   cin,
    input  logic                   resetn,
    reaction_timer_multi_if.slave  bus
);
    localparam int CNT_W = 4 * DIGITS;
    localparam int SEL_W = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
    localparam int PRE_W = $clog2(TICK_DIV);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_FOUL = 3'd4;

    localparam logic [CNT_W-1:0] ALL9 = {DIGITS{4'h9}};

    logic [2:0]         state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [31:0]        delay_q, delay_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [SEL_W-1:0]   winner_q, winner_d;
    logic               timeout_q, timeout_d;
    logic               new_best_q, new_best_d;
    logic               start_q, start_d;
    logic [PLAYERS-1:0] react_q, react_d;
    logic [CNT_W-1:0]   best_q [PLAYERS];
    logic [CNT_W-1:0]   best_d [PLAYERS];

    logic               tick;
    logic               start_edge;
    logic [PLAYERS-1:0] react_edge;
    logic               react_any;
    logic [SEL_W-1:0]   first_idx;
    logic [31:0]        delay_load;

    function automatic logic [CNT_W-1:0] bcd_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        logic             c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Free-running prescaler, Galois LFSR and input edge registers.
    always_comb begin
        tick       = (pre_q == PRE_W'(TICK_DIV - 1));
        pre_d      = tick ? '0 : pre_q + PRE_W'(1);
        lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
        start_d    = bus.start;
        react_d    = bus.react;
        start_edge = bus.start & ~start_q;
        react_edge = bus.react & ~react_q;
        react_any  = |react_edge;
        delay_load = 32'(MIN_DELAY) + (32'(lfsr_q) & 32'(DELAY_MASK));
    end

    // Lowest-index asserting player wins simultaneous presses.
    always_comb begin
        first_idx = '0;
        for (int i = PLAYERS - 1; i >= 0; i--) begin
            if (react_edge[i]) first_idx = SEL_W'(i);
        end
    end

    // Sequencer: fore-period, counting, arbitration and best-time update.
    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        count_d    = count_q;
        winner_d   = winner_q;
        timeout_d  = timeout_q;
        new_best_d = 1'b0;
        best_d     = best_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FOUL: begin
                if (start_edge) begin
                    state_d   = ST_WAIT;
                    delay_d   = delay_load;
                    count_d   = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (react_any) begin
                    state_d  = ST_FOUL;
                    winner_d = first_idx;
                end else if (tick) begin
                    if (delay_q <= 32'd1) begin
                        state_d = ST_RUN;
                        delay_d = '0;
                    end else begin
                        delay_d = delay_q - 32'd1;
                    end
                end
            end
            ST_RUN: begin
                if (react_any) begin
                    // The tick of this cycle is dropped so the shown time is the press time.
                    state_d  = ST_DONE;
                    winner_d = first_idx;
                    // Valid BCD orders the same as plain binary, so a vector compare suffices.
                    if (count_q < best_q[first_idx]) begin
                        best_d[first_idx] = count_q;
                        new_best_d        = 1'b1;
                    end
                end else if (tick) begin
                    if (count_q == ALL9) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                    end else begin
                        count_d = bcd_inc(count_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A clear overrides any update in the same cycle, including its pulse.
        if (bus.clear_best) begin
            for (int i = 0; i < PLAYERS; i++) best_d[i] = ALL9;
            new_best_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge cin or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            pre_q      <= '0;
            lfsr_q     <= 16'hACE1;
            delay_q    <= '0;
            count_q    <= '0;
            winner_q   <= '0;
            timeout_q  <= 1'b0;
            new_best_q <= 1'b0;
            start_q    <= 1'b0;
            react_q    <= '0;
            for (int i = 0; i < PLAYERS; i++) best_q[i] <= ALL9;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            lfsr_q     <= lfsr_d;
            delay_q    <= delay_d;
            count_q    <= count_d;
            winner_q   <= winner_d;
            timeout_q  <= timeout_d;
            new_best_q <= new_best_d;
            start_q    <= start_d;
            react_q    <= react_d;
            for (int i = 0; i < PLAYERS; i++) best_q[i] <= best_d[i];
        end
    end

    // Output decode straight off the registers.
    always_comb begin
        bus.state_o  = state_q;
        bus.winner   = winner_q;
        bus.new_best = new_best_q;
        bus.timeout  = timeout_q;
        if (state_q == ST_RUN) begin
            bus.led = '1;
        end else if ((state_q == ST_DONE && !timeout_q) || state_q == ST_FOUL) begin
            bus.led = LEDS'(1) << winner_q;
        end else begin
            bus.led = '0;
        end
        if (bus.show_best) begin
            if (32'(bus.best_sel) < PLAYERS) bus.bcd_disp = best_q[bus.best_sel];
            else                             bus.bcd_disp = ALL9;
        end else begin
            bus.bcd_disp = count_q;
        end
    end
endmodule
